// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch path
// and the load/store path. One transaction in flight, registered request and
// response, data-over-fetch priority with a starvation limit on fetch.
// Optional macro ARB_PERF_EN adds free-running 32-bit perf counters.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_rsp_valid,
    output logic [XLEN-1:0]   if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [XLEN-1:0]   d_addr,
    input  logic              d_we,
    input  logic [XLEN/8-1:0] d_be,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_rsp_valid,
    output logic [XLEN-1:0]   d_rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_if_stall
`endif
);
    localparam int         BEW        = XLEN / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic       OWN_IF     = 1'b0;
    localparam logic       OWN_D      = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              owner_q, owner_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              we_q, we_d;
    logic [BEW-1:0]    be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   if_rsp_data_q, if_rsp_data_d;
    logic [XLEN-1:0]   d_rsp_data_q, d_rsp_data_d;

    logic              grant_d, grant_if;

    // Arbitration: data wins unless fetch has been passed over STARVE_MAX times
    always_comb begin
        grant_d  = d_req_valid && !(if_req_valid && (starve_cnt_q == STARVE_LIM));
        grant_if = if_req_valid && !grant_d;
    end

    // Next-state, request latching and per-state outputs
    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        we_d          = we_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        if_rsp_data_d = if_rsp_data_q;
        d_rsp_data_d  = d_rsp_data_q;
        if_req_ready  = 1'b0;
        d_req_ready   = 1'b0;
        mem_req_valid = 1'b0;
        if_rsp_valid  = 1'b0;
        d_rsp_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                // Readies are gated by reset so nothing looks accepted while
                // the block is being held in reset.
                if (!reset) begin
                    if_req_ready = grant_if;
                    d_req_ready  = grant_d;
                end
                if (grant_d) begin
                    addr_d  = d_addr;
                    we_d    = d_we;
                    be_d    = d_be;
                    wdata_d = d_wdata;
                    owner_d = OWN_D;
                    state_d = ISSUE;
                    if (if_req_valid && (starve_cnt_q != STARVE_LIM))
                        starve_cnt_d = starve_cnt_q + 4'd1;
                end else if (grant_if) begin
                    addr_d       = if_addr;
                    we_d         = 1'b0;
                    be_d         = '1;
                    wdata_d      = '0;
                    owner_d      = OWN_IF;
                    starve_cnt_d = 4'd0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    if (we_q) begin
                        // Stores get no memory response; ack carries zero data.
                        d_rsp_data_d = '0;
                        state_d      = RESP;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    if (owner_q == OWN_D) d_rsp_data_d  = mem_rsp_data;
                    else                  if_rsp_data_d = mem_rsp_data;
                    state_d = RESP;
                end
            end
            RESP: begin
                if_rsp_valid = (owner_q == OWN_IF);
                d_rsp_valid  = (owner_q == OWN_D);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request/response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            starve_cnt_q  <= 4'd0;
            owner_q       <= OWN_IF;
            addr_q        <= '0;
            we_q          <= 1'b0;
            be_q          <= '0;
            wdata_q       <= '0;
            if_rsp_data_q <= '0;
            d_rsp_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            if_rsp_data_q <= if_rsp_data_d;
            d_rsp_data_q  <= d_rsp_data_d;
        end
    end

    // Memory request comes straight from the latched registers, so it stays
    // stable for as long as the memory stalls.
    always_comb begin
        mem_addr    = addr_q;
        mem_we      = we_q;
        mem_be      = be_q;
        mem_wdata   = wdata_q;
        if_rsp_data = if_rsp_data_q;
        d_rsp_data  = d_rsp_data_q;
    end

`ifdef ARB_PERF_EN
    logic [31:0] perf_if_grants_q, perf_if_grants_d;
    logic [31:0] perf_d_grants_q, perf_d_grants_d;
    logic [31:0] perf_if_stall_q, perf_if_stall_d;

    // Perf counters: grants per port and fetch-stall cycles, wrapping
    always_comb begin
        perf_if_grants_d = perf_if_grants_q;
        perf_d_grants_d  = perf_d_grants_q;
        perf_if_stall_d  = perf_if_stall_q;
        if (if_req_valid && if_req_ready) perf_if_grants_d = perf_if_grants_q + 32'd1;
        if (d_req_valid && d_req_ready)   perf_d_grants_d  = perf_d_grants_q + 32'd1;
        if (if_req_valid && !if_req_ready) perf_if_stall_d = perf_if_stall_q + 32'd1;
    end

    // Perf counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_if_grants_q <= '0;
            perf_d_grants_q  <= '0;
            perf_if_stall_q  <= '0;
        end else begin
            perf_if_grants_q <= perf_if_grants_d;
            perf_d_grants_q  <= perf_d_grants_d;
            perf_if_stall_q  <= perf_if_stall_d;
        end
    end

    assign perf_if_grants = perf_if_grants_q;
    assign perf_d_grants  = perf_d_grants_q;
    assign perf_if_stall  = perf_if_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a response scoreboard. Stimulus
// pushes expected responses; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid = 1'b0, if_req_ready;
    logic [31:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid = 1'b0, d_req_ready;
    logic [31:0] d_addr = '0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_wdata = '0;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
`ifdef ARB_PERF_EN
    logic [31:0] perf_if_grants, perf_d_grants, perf_if_stall;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef ARB_PERF_EN
        , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
        .perf_if_stall(perf_if_stall)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: ready unless stalled, read data one cycle after acceptance
    logic [31:0] mem_arr [logic [31:0]];
    int          stall_left = 0;
    bit          mem_auto = 1'b1;
    logic        mdl_v = 1'b0, inj_v = 1'b0;
    logic [31:0] mdl_d = '0, inj_d = '0;

    assign mem_req_ready = (stall_left == 0);
    assign mem_rsp_valid = mdl_v | inj_v;
    assign mem_rsp_data  = inj_v ? inj_d : mdl_d;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin : mem_model
        bit          fire, stl, wr;
        logic [31:0] a, wd, nv;
        logic [3:0]  be;
        fire = mem_req_valid && mem_req_ready && !reset;
        stl  = mem_req_valid && !mem_req_ready && !reset;
        wr = mem_we; a = mem_addr; wd = mem_wdata; be = mem_be;
        #1;
        mdl_v = 1'b0;
        if (stl) stall_left--;
        if (fire) begin
            nv = mem_arr.exists(a) ? mem_arr[a] : 32'h0;
            if (wr) begin
                for (int b = 0; b < 4; b++) if (be[b]) nv[8*b +: 8] = wd[8*b +: 8];
                mem_arr[a] = nv;
            end else if (mem_auto) begin
                mdl_v = 1'b1;
                mdl_d = nv;
            end
        end
    end

    // Scoreboard and monitor
    typedef struct { logic [31:0] data; int cyc; } exp_t;
    exp_t        q_if[$];
    exp_t        q_d[$];
    byte         gq[$];
    int          n_pulse = 0;
    int          iss_cyc = -1;
    logic        iss_we;
    logic [3:0]  iss_be;
    logic [31:0] iss_addr, iss_wdata;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (if_rsp_valid) begin
                n_pulse++;
                if (q_if.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL if_rsp_unexpected: pulse with data 0x%08h, none expected", if_rsp_data);
                end else begin
                    e = q_if.pop_front();
                    chk("if_rsp_data", if_rsp_data, e.data);
                    if (e.cyc >= 0) chk("if_rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (d_rsp_valid) begin
                n_pulse++;
                if (q_d.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL d_rsp_unexpected: pulse with data 0x%08h, none expected", d_rsp_data);
                end else begin
                    e = q_d.pop_front();
                    chk("d_rsp_data", d_rsp_data, e.data);
                    if (e.cyc >= 0) chk("d_rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (if_req_ready || d_req_ready)
                chk("ready_onehot", 32'(if_req_ready && d_req_ready), 32'd0);
            if (if_req_valid && if_req_ready) gq.push_back(8'h49);
            if (d_req_valid && d_req_ready)   gq.push_back(8'h44);
            if (mem_req_valid && mem_req_ready) begin
                iss_cyc = cyc; iss_we = mem_we; iss_be = mem_be;
                iss_addr = mem_addr; iss_wdata = mem_wdata;
            end
        end
    end

    task automatic wait_accept(input bit is_d, output int acc);
        acc = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (is_d ? d_req_ready : if_req_ready) begin acc = cyc; break; end
        end
        if (acc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: %s ready never seen, required within 64 cycles", is_d ? "d" : "if");
        end
    endtask

    task automatic req_fetch(input logic [31:0] a, input logic [31:0] exp, input int lat, output int acc);
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = a;
        wait_accept(1'b0, acc);
        if (acc >= 0) q_if.push_back('{data: exp, cyc: (lat > 0) ? acc + lat : -1});
        @(posedge clk); #1;
        if_req_valid = 1'b0;
    endtask

    task automatic req_data(input logic [31:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, input logic [31:0] exp, input int lat,
                            output int acc);
        @(posedge clk); #1;
        d_req_valid = 1'b1; d_addr = a; d_we = we; d_be = be; d_wdata = wd;
        wait_accept(1'b1, acc);
        if (acc >= 0) q_d.push_back('{data: exp, cyc: (lat > 0) ? acc + lat : -1});
        @(posedge clk); #1;
        d_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q_if.size() != 0 || q_d.size() != 0); i++) @(negedge clk);
        if (q_if.size() != 0 || q_d.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d if / %0d d responses outstanding, required 0", q_if.size(), q_d.size());
        end
        @(negedge clk);
    endtask

    // Both requesters held valid until n grants; checks grant order
    task automatic run_both(input int n, input string exp_seq);
        int got, first, t0;
        gq.delete();
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = 32'h100;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF; d_wdata = '0;
        t0 = cyc; got = 0; first = -1;
        for (int i = 0; i < 200 && got < n; i++) begin
            @(negedge clk);
            if (if_req_ready) begin q_if.push_back('{data: 32'h00500093, cyc: -1}); got++; end
            if (d_req_ready)  begin q_d.push_back('{data: 32'h0000BEEF, cyc: -1}); got++; end
            if (got > 0 && first < 0) first = cyc;
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        chk("first_grant_cycle", 32'(first), 32'(t0));
        drain();
        for (int i = 0; i < n; i++)
            chk($sformatf("grant_seq[%0d]", i), (gq.size() > i) ? 32'(gq[i]) : 32'h0, 32'(exp_seq[i]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid_ready"}, {25'd0, if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid,
                                    mem_req_valid, mem_we, 1'b0}, 32'd0);
        chk({tag, "_if_rsp_data"}, if_rsp_data, 32'd0);
        chk({tag, "_d_rsp_data"}, d_rsp_data, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc, acc2, pulses;
        logic [31:0] snap_if, snap_d;
        mem_arr[32'h100] = 32'h00500093;

        // Reset state, with both requesters already asserting valid
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1; chk_zero("reset");
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b0;

        // Fetch only: response at accept+3, fetch request is a full-word read
        req_fetch(32'h100, 32'h00500093, 3, acc);
        drain();
        chk("fetch_mem_we", 32'(iss_we), 32'd0);
        chk("fetch_mem_be", 32'(iss_be), 32'hF);
        chk("fetch_mem_addr", iss_addr, 32'h100);
        chk("fetch_issue_cycle", 32'(iss_cyc), 32'(acc + 1));

        // Store: issued at accept+1, zero-data ack at accept+2
        req_data(32'h200, 1'b1, 4'h3, 32'hDEADBEEF, 32'h0, 2, acc);
        drain();
        chk("store_mem_we", 32'(iss_we), 32'd1);
        chk("store_mem_be", 32'(iss_be), 32'h3);
        chk("store_mem_addr", iss_addr, 32'h200);
        chk("store_mem_wdata", iss_wdata, 32'hDEADBEEF);
        chk("store_issue_cycle", 32'(iss_cyc), 32'(acc + 1));

        // Starvation limit: D,D,D,I repeating
        run_both(8, "DDDIDDDI");

        // Memory stalls 5 cycles; fetch waits behind the store until after RESP
        stall_left = 5;
        req_data(32'h300, 1'b1, 4'hF, 32'hA5A55A5A, 32'h0, 7, acc);
        if_req_valid = 1'b1; if_addr = 32'h100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_mem_req_valid", 32'(mem_req_valid), 32'd1);
            chk("stall_mem_req_ready", 32'(mem_req_ready), 32'd0);
            chk("stall_mem_addr", mem_addr, 32'h300);
            chk("stall_mem_wdata", mem_wdata, 32'hA5A55A5A);
            chk("stall_mem_be", 32'(mem_be), 32'hF);
            chk("stall_if_req_ready", 32'(if_req_ready), 32'd0);
        end
        wait_accept(1'b0, acc2);
        if (acc2 >= 0) q_if.push_back('{data: 32'h00500093, cyc: acc2 + 3});
        chk("stall_fetch_accept_cycle", 32'(acc2), 32'(acc + 8));
        @(posedge clk); #1; if_req_valid = 1'b0;
        drain();

        // Spurious memory response in IDLE is ignored
        snap_if = if_rsp_data; snap_d = d_rsp_data; pulses = n_pulse;
        @(posedge clk); #1; inj_v = 1'b1; inj_d = 32'h1234;
        @(posedge clk); #1; inj_v = 1'b0;
        repeat (3) @(negedge clk);
        chk("spurious_pulses", 32'(n_pulse), 32'(pulses));
        chk("spurious_if_rsp_data", if_rsp_data, snap_if);
        chk("spurious_d_rsp_data", d_rsp_data, snap_d);

        // Reset while waiting on a load; late response must be dropped
        mem_auto = 1'b0;
        @(posedge clk); #1;
        if_req_valid = 1'b1; d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
        wait_accept(1'b1, acc);
        @(posedge clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(posedge clk); #2;
        chk("wait_rsp_mem_req_valid", 32'(mem_req_valid), 32'd0);
        reset = 1'b1;
        #1; chk_zero("midreset");
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        pulses = n_pulse;
        @(posedge clk); #1; inj_v = 1'b1; inj_d = 32'hCAFEF00D;
        @(posedge clk); #1; inj_v = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_rsp_pulses", 32'(n_pulse), 32'(pulses));
        chk("late_rsp_d_data", d_rsp_data, 32'h0);
        chk("late_rsp_if_data", if_rsp_data, 32'h0);
        mem_auto = 1'b1;

        // After reset: IDLE with cleared starvation count
        run_both(4, "DDDI");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
